game_turn_controller: RTL and testbench
=======================================

# game_turn_controller

Two-player turn sequencer for the VGA bomb-chase game. It owns the game state machine (idle, player-1 turn, player-2 turn, done), per-turn countdown, score counters and bomb placement. Collision logic drives `hit`; the controller decides whose turn it is, enables movement, relocates the bomb and exposes state and scores to the LEDs, SSD and pixel logic.

## Interface
Parameters:
- `TURN_TICKS`, default 64: ticks allowed per turn before the turn passes without a score.
- `WIN_SCORE`, default 10: score that ends the game (4'b1010).

Ports:
- `clk`  in  1  system clock (VGA pixel-domain clock).
- `reset_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle game-rate strobe (~24 Hz).
- `start`  in  1  level start switch.
- `hit`  in  1  level; high while the active player overlaps the bomb.
- `state`  out  2  00 QI, 01 QGAME_1, 10 QGAME_2, 11 QDONE.
- `move_en_p1`, `move_en_p2`  out  1 each  movement enable for each player.
- `p1_score`, `p2_score`  out  4 each  scores.
- `turn_left`  out  7  remaining ticks in the current turn.
- `bomb_x`  out  10  bomb centre X.
- `bomb_y`  out  10  bomb centre Y.
- `bomb_relocate`  out  1  one-cycle pulse when bomb moves.
- `winner`  out  2  00 none, 01 P1, 10 P2.

## Operation
- Reset: state QI, scores 0, `turn_left`=TURN_TICKS, `bomb_x`=240, `bomb_y`=240, `move_en_*`=0, `bomb_relocate`=0, `winner`=00.
- `start` and `hit` are registered and rising-edge detected internally; a held `hit` scores once.
- QI: scores held at 0, `winner`=00. Rising edge of `start` -> QGAME_1, load `turn_left`=TURN_TICKS.
- QGAME_1/QGAME_2: only the active player's `move_en` is high. Each `tick` decrements `turn_left`; at 0 -> other turn, reload, no score.
- `hit` rising edge in a game state: active score +1, `bomb_relocate` pulse, new bomb position, switch turn, reload `turn_left`.
- If the incremented score equals WIN_SCORE -> QDONE; `winner` set; both `move_en` low.
- Simultaneous `hit` edge and expiring `tick`: hit wins (score counted, single turn switch).
- `hit` in QI or QDONE ignored; `tick` ignored outside game states.
- QDONE: holds scores and winner until `start` low for one cycle -> QI (scores cleared on entry to QI).
- `start` low during a game state -> QI (abort); scores cleared.
- Scores saturate at WIN_SCORE; never wrap.
- Bomb position constrained to X 20..620, Y 20..460.

## Timing
- All outputs registered; changes visible after the clock edge on which the internal edge-detect sees the event (two edges after `hit`/`start` asserted, due to input register).
- `bomb_relocate` high exactly one cycle, same cycle new `bomb_x/bomb_y` appear.
- `turn_left` updates on the edge where `tick` is sampled high.
- Asynchronous reset mid-game returns all outputs to reset values immediately; no pending pulse survives.

## Configuration
- `GAME_CTRL_LFSR_EN` defined: bomb position from a free-running 16-bit LFSR (taps 16,14,13,11, seed 16'hACE1), sampled on relocate and folded into the legal range by modulo-subtract.
- Undefined: bomb cycles through a fixed 4-entry table (100,60), (540,60), (540,420), (100,420), index advancing on each relocate, reset to index 0 (bomb at 240,240 until first relocate).

## Structure
- Shared package: state encodings QI/QGAME_1/QGAME_2/QDONE, winner encodings, bomb range limits, screen constants (640x480).
- One sub-module: `bomb_pos_gen` (LFSR or table, relocate strobe in, X/Y out), selected by the macro.

## Test plan
- Reset, `start` rising -> state 01, `move_en_p1`=1, `move_en_p2`=0, `turn_left`=64.
- 64 ticks with no hit -> state 10, scores 0/0, `turn_left`=64.
- `hit` held 5 cycles in QGAME_1 -> `p1_score`=1 exactly, one `bomb_relocate` pulse, state 10.
- Hit edge coincident with final tick -> score +1, single switch to the other turn.
- Alternate scoring until P2 reaches 10 -> state 11, `winner`=10, both `move_en` low; extra hits ignored; `start` low -> QI, scores 0.
- `reset_n` low mid-turn with `p1_score`=3 -> all outputs to reset values asynchronously.

Source files
------------

// File: rtl/game_turn_controller_pkg.sv
// Shared definitions for the bomb-chase turn controller: state and winner
// encodings, screen geometry, bomb limits and small helper functions.
package game_turn_controller_pkg;

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } game_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Bomb centre must stay 20 pixels inside every screen edge.
  localparam logic [9:0] BOMB_X_MIN   = 10'd20;
  localparam logic [9:0] BOMB_X_MAX   = 10'(SCREEN_W - 20);
  localparam logic [9:0] BOMB_Y_MIN   = 10'd20;
  localparam logic [9:0] BOMB_Y_MAX   = 10'(SCREEN_H - 20);
  localparam logic [9:0] BOMB_X_RESET = 10'd240;
  localparam logic [9:0] BOMB_Y_RESET = 10'd240;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic game_state_t other_turn(input game_state_t s);
    return (s == QGAME_1) ? QGAME_2 : QGAME_1;
  endfunction

  // Saturating score increment; a score never passes the winning limit.
  function automatic logic [3:0] score_inc(input logic [3:0] s, input logic [3:0] lim);
    return (s >= lim) ? lim : s + 4'd1;
  endfunction

endpackage

// File: rtl/game_turn_controller_bomb_pos_gen.sv
// Bomb position source. GAME_CTRL_LFSR_EN selects a free-running LFSR folded
// into the legal area; otherwise a fixed four-corner table is stepped through.
module bomb_pos_gen
  import game_turn_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       relocate,
  output logic [9:0] bomb_x,
  output logic [9:0] bomb_y
);

`ifdef GAME_CTRL_LFSR_EN
  localparam logic [9:0] X_SPAN = BOMB_X_MAX - BOMB_X_MIN + 10'd1;
  localparam logic [8:0] Y_SPAN = 9'(BOMB_Y_MAX - BOMB_Y_MIN + 10'd1);

  logic [15:0] lfsr;
  logic        fb;
  logic [9:0]  x_raw, x_off;
  logic [8:0]  y_raw, y_off;

  // Taps 16,14,13,11 (bits 15,13,12,10).
  assign fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign x_raw = lfsr[9:0];
  assign y_raw = lfsr[15:7];
  // A single subtract suffices: raw ranges are below twice the spans.
  assign x_off = (x_raw >= X_SPAN) ? x_raw - X_SPAN : x_raw;
  assign y_off = (y_raw >= Y_SPAN) ? y_raw - Y_SPAN : y_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr   <= LFSR_SEED;
      bomb_x <= BOMB_X_RESET;
      bomb_y <= BOMB_Y_RESET;
    end else begin
      lfsr <= {lfsr[14:0], fb};
      if (relocate) begin
        bomb_x <= BOMB_X_MIN + x_off;
        bomb_y <= BOMB_Y_MIN + {1'b0, y_off};
      end
    end
  end
`else
  logic [1:0] idx;

  function automatic logic [9:0] tbl_x(input logic [1:0] i);
    return (i == 2'd0 || i == 2'd3) ? 10'd100 : 10'd540;
  endfunction

  function automatic logic [9:0] tbl_y(input logic [1:0] i);
    return (i == 2'd0 || i == 2'd1) ? 10'd60 : 10'd420;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx    <= 2'd0;
      bomb_x <= BOMB_X_RESET;
      bomb_y <= BOMB_Y_RESET;
    end else if (relocate) begin
      idx    <= idx + 2'd1;
      bomb_x <= tbl_x(idx);
      bomb_y <= tbl_y(idx);
    end
  end
`endif

endmodule

// File: rtl/game_turn_controller.sv
// Two-player turn sequencer: state machine, turn countdown, scores and bomb
// relocation. Build option: GAME_CTRL_LFSR_EN (random bomb placement).
module game_turn_controller
  import game_turn_controller_pkg::*;
#(
  parameter int TURN_TICKS = 64,
  parameter int WIN_SCORE  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start,
  input  logic       hit,
  output logic [1:0] state,
  output logic       move_en_p1,
  output logic       move_en_p2,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [6:0] turn_left,
  output logic [9:0] bomb_x,
  output logic [9:0] bomb_y,
  output logic       bomb_relocate,
  output logic [1:0] winner
);

  localparam logic [6:0] TURN_RELOAD = 7'(TURN_TICKS);
  localparam logic [3:0] WIN_LIMIT   = 4'(WIN_SCORE);

  logic        start_q, start_d, hit_q, hit_d;
  logic        start_rise, hit_rise;
  game_state_t state_r, state_nx;
  winner_t     winner_r, winner_nx;
  logic [3:0]  p1_r, p1_nx, p2_r, p2_nx, scored;
  logic [6:0]  turn_r, turn_nx;
  logic        reloc_nx;

  // Inputs come from switches and the collision path; register, then edge-detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= 1'b0;
      start_d <= 1'b0;
      hit_q   <= 1'b0;
      hit_d   <= 1'b0;
    end else begin
      start_q <= start;
      start_d <= start_q;
      hit_q   <= hit;
      hit_d   <= hit_q;
    end
  end

  assign start_rise = start_q & ~start_d;
  assign hit_rise   = hit_q & ~hit_d;

  always_comb begin
    state_nx  = state_r;
    winner_nx = winner_r;
    p1_nx     = p1_r;
    p2_nx     = p2_r;
    turn_nx   = turn_r;
    reloc_nx  = 1'b0;
    scored    = 4'd0;
    case (state_r)
      QI: begin
        p1_nx     = 4'd0;
        p2_nx     = 4'd0;
        winner_nx = WIN_NONE;
        turn_nx   = TURN_RELOAD;
        if (start_rise) state_nx = QGAME_1;
      end
      QGAME_1, QGAME_2: begin
        if (!start_q) begin
          state_nx  = QI;
          p1_nx     = 4'd0;
          p2_nx     = 4'd0;
          winner_nx = WIN_NONE;
          turn_nx   = TURN_RELOAD;
        end else if (hit_rise) begin
          // A hit takes precedence over an expiring tick in the same cycle.
          reloc_nx = 1'b1;
          turn_nx  = TURN_RELOAD;
          if (state_r == QGAME_1) begin
            scored = score_inc(p1_r, WIN_LIMIT);
            p1_nx  = scored;
          end else begin
            scored = score_inc(p2_r, WIN_LIMIT);
            p2_nx  = scored;
          end
          if (scored == WIN_LIMIT) begin
            state_nx  = QDONE;
            winner_nx = (state_r == QGAME_1) ? WIN_P1 : WIN_P2;
          end else begin
            state_nx = other_turn(state_r);
          end
        end else if (tick) begin
          if (turn_r <= 7'd1) begin
            state_nx = other_turn(state_r);
            turn_nx  = TURN_RELOAD;
          end else begin
            turn_nx = turn_r - 7'd1;
          end
        end
      end
      QDONE: begin
        if (!start_q) begin
          state_nx  = QI;
          p1_nx     = 4'd0;
          p2_nx     = 4'd0;
          winner_nx = WIN_NONE;
          turn_nx   = TURN_RELOAD;
        end
      end
      default: state_nx = QI;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= QI;
      winner_r      <= WIN_NONE;
      p1_r          <= 4'd0;
      p2_r          <= 4'd0;
      turn_r        <= TURN_RELOAD;
      bomb_relocate <= 1'b0;
      move_en_p1    <= 1'b0;
      move_en_p2    <= 1'b0;
    end else begin
      state_r       <= state_nx;
      winner_r      <= winner_nx;
      p1_r          <= p1_nx;
      p2_r          <= p2_nx;
      turn_r        <= turn_nx;
      bomb_relocate <= reloc_nx;
      move_en_p1    <= (state_nx == QGAME_1);
      move_en_p2    <= (state_nx == QGAME_2);
    end
  end

  // The generator updates on the same edge that raises bomb_relocate.
  bomb_pos_gen u_bomb_pos_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .relocate (reloc_nx),
    .bomb_x   (bomb_x),
    .bomb_y   (bomb_y)
  );

  assign state     = state_r;
  assign winner    = winner_r;
  assign p1_score  = p1_r;
  assign p2_score  = p2_r;
  assign turn_left = turn_r;

endmodule

// File: tb/tb_game_turn_controller.sv
// Randomised and directed bench for game_turn_controller (default bomb table
// build), checked cycle by cycle against a game-rules reference model.
module tb_game_turn_controller;

  localparam int T_TICKS = 64;
  localparam int WIN     = 10;

  logic       clk = 1'b0;
  logic       reset_n, tick, start, hit;
  logic [1:0] state, winner;
  logic       move_en_p1, move_en_p2, bomb_relocate;
  logic [3:0] p1_score, p2_score;
  logic [6:0] turn_left;
  logic [9:0] bomb_x, bomb_y;

  int tests_run    = 0;
  int tests_failed = 0;
  int reloc_seen   = 0;

  // Reference model: phase 0 idle, 1 player-1 turn, 2 player-2 turn, 3 over.
  int m_phase, m_p1, m_p2, m_left, m_win, m_reloc, m_bx, m_by, m_moves;
  bit hit_hist[$];
  bit start_hist[$];
  int tbl_x[4] = '{100, 540, 540, 100};
  int tbl_y[4] = '{60, 60, 420, 420};

  game_turn_controller #(.TURN_TICKS(T_TICKS), .WIN_SCORE(WIN)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tick          (tick),
    .start         (start),
    .hit           (hit),
    .state         (state),
    .move_en_p1    (move_en_p1),
    .move_en_p2    (move_en_p2),
    .p1_score      (p1_score),
    .p2_score      (p2_score),
    .turn_left     (turn_left),
    .bomb_x        (bomb_x),
    .bomb_y        (bomb_y),
    .bomb_relocate (bomb_relocate),
    .winner        (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_p1 = 0; m_p2 = 0; m_left = T_TICKS; m_win = 0;
    m_reloc = 0; m_bx = 240; m_by = 240; m_moves = 0;
    hit_hist   = '{1'b0, 1'b0};
    start_hist = '{1'b0, 1'b0};
  endtask

  task automatic back_to_idle();
    m_phase = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_left = T_TICKS;
  endtask

  // Game rules applied for one clock edge; hit/start are seen two edges late.
  task automatic model_edge(input bit t, input bit h, input bit s);
    bit hit_new, start_new, start_lvl;
    hit_new   = hit_hist[1] && !hit_hist[0];
    start_new = start_hist[1] && !start_hist[0];
    start_lvl = start_hist[1];
    m_reloc   = 0;
    if (m_phase == 0) begin
      if (start_new) begin m_phase = 1; m_left = T_TICKS; end
    end else if (m_phase == 3) begin
      if (!start_lvl) back_to_idle();
    end else if (!start_lvl) begin
      back_to_idle();
    end else if (hit_new) begin
      int sc;
      if (m_phase == 1) begin m_p1 = (m_p1 + 1 > WIN) ? WIN : m_p1 + 1; sc = m_p1; end
      else begin m_p2 = (m_p2 + 1 > WIN) ? WIN : m_p2 + 1; sc = m_p2; end
      m_reloc = 1;
      m_bx = tbl_x[m_moves % 4];
      m_by = tbl_y[m_moves % 4];
      m_moves++;
      m_left = T_TICKS;
      if (sc == WIN) begin m_win = m_phase; m_phase = 3; end
      else m_phase = 3 - m_phase;
    end else if (t) begin
      m_left = m_left - 1;
      if (m_left == 0) begin m_phase = 3 - m_phase; m_left = T_TICKS; end
    end
    void'(hit_hist.pop_front());
    hit_hist.push_back(h);
    void'(start_hist.pop_front());
    start_hist.push_back(s);
  endtask

  task automatic compare_all();
    check("state", state, m_phase);
    check("move_en_p1", move_en_p1, (m_phase == 1) ? 1 : 0);
    check("move_en_p2", move_en_p2, (m_phase == 2) ? 1 : 0);
    check("p1_score", p1_score, m_p1);
    check("p2_score", p2_score, m_p2);
    check("turn_left", turn_left, m_left);
    check("bomb_x", bomb_x, m_bx);
    check("bomb_y", bomb_y, m_by);
    check("bomb_relocate", bomb_relocate, m_reloc);
    check("winner", winner, m_win);
  endtask

  // Drive one cycle of inputs away from the edge, then check just after it.
  task automatic step(input bit t, input bit h, input bit s);
    tick = t; hit = h; start = s;
    model_edge(t, h, s);
    @(posedge clk);
    #1;
    if (bomb_relocate) reloc_seen++;
    compare_all();
  endtask

  task automatic pulse_hit();
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    bit h_lvl, s_lvl;
    reset_n = 1'b0; tick = 1'b0; start = 1'b0; hit = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;

    // start rising edge opens player 1's turn
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("start_state", state, 1);
    check("start_men1", move_en_p1, 1);
    check("start_men2", move_en_p2, 0);
    check("start_turn", turn_left, 64);

    // a full turn of ticks with no hit passes the turn
    run_ticks(63);
    check("tick63_turn", turn_left, 1);
    run_ticks(1);
    check("expire_state", state, 2);
    check("expire_scores", p1_score + p2_score, 0);
    check("expire_turn", turn_left, 64);

    // held hit scores once
    run_ticks(64);
    reloc_seen = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("held_p1", p1_score, 1);
    check("held_pulses", reloc_seen, 1);
    check("held_state", state, 2);

    // hit edge on the expiring tick: one score, one switch
    run_ticks(63);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("coinc_p2", p2_score, 1);
    check("coinc_state", state, 1);
    check("coinc_turn", turn_left, 64);

    // abort
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("abort_state", state, 0);
    check("abort_p1", p1_score, 0);

    // build p1_score=3, then reset while the relocate pulse is high
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      pulse_hit();
      run_ticks(64);
    end
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("pre_reset_p1", p1_score, 3);
    check("pre_reset_pulse", bomb_relocate, 1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // alternate scoring; player 2 reaches the limit first
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    run_ticks(64);
    for (int i = 0; i < 19; i++) pulse_hit();
    check("win_state", state, 3);
    check("win_winner", winner, 2);
    check("win_men", {move_en_p1, move_en_p2}, 0);
    check("win_p2", p2_score, 10);
    check("win_p1", p1_score, 9);
    pulse_hit();
    pulse_hit();
    run_ticks(3);
    check("done_p2_hold", p2_score, 10);
    check("done_p1_hold", p1_score, 9);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("done_idle", state, 0);
    check("done_clear", p1_score + p2_score, 0);

    // randomised play
    h_lvl = 1'b0; s_lvl = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) h_lvl = ~h_lvl;
      if (s_lvl && $urandom_range(0, 299) == 0) s_lvl = 1'b0;
      else if (!s_lvl && $urandom_range(0, 3) == 0) s_lvl = 1'b1;
      step(1'($urandom_range(0, 1)), h_lvl, s_lvl);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
